ixc_skid_83: RTL and testbench

Registered valid/ready skid buffer for an 83-bit data bus, placed directly upstream of the 83-bit bitwise assign stage in the emulation template library. Its `out_data` drives the assign stage's `R` input. It breaks the combinational ready path between producer and consumer while sustaining one transfer per cycle. A 16-bit output-transfer counter is provided for emulation-side debug visibility.

---
 rtl/ixc_skid_83_if.sv | 30 +++
 rtl/ixc_skid_83.sv | 97 +++++++++
 tb/tb_ixc_skid_83.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ixc_skid_83_if.sv
// Valid/ready handshake bundle for the ixc_skid_83 skid buffer.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface ixc_skid_83_if #(
  parameter int unsigned WIDTH = 83
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/ixc_skid_83.sv
// Two-entry registered skid buffer feeding the 83-bit assign stage's R input;
// in_ready comes straight from a flop, so no combinational ready path crosses it.
module ixc_skid_83 #(
  parameter int unsigned WIDTH = 83,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  ixc_skid_83_if.slave     bus,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      xfer_q      <= xfer_d;
    end
  end

  // Next-state: occupancy transitions, flush overrides normal flow
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs and storage: flag flops track the next state so they stay registered
  always_comb begin
    main_d      = main_q;
    skid_d      = skid_q;
    xfer_d      = xfer_q + CNT_W'(out_fire);
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) main_d = bus.in_data;
        ST_ONE: begin
          if (in_fire && out_fire) main_d = bus.in_data;
          else if (in_fire)        skid_d = bus.in_data;
        end
        ST_FULL:  if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign count         = 2'(state_q);
  assign xfer_cnt      = xfer_q;

endmodule

// File: tb/tb_ixc_skid_83.sv
// Randomized scoreboard bench for ixc_skid_83: a queue of accepted words models
// the buffer contents; a negedge monitor checks every output handshake.
module tb_ixc_skid_83;
  localparam int unsigned W     = 83;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       count;
  logic [CNT_W-1:0] xfer_cnt;

  ixc_skid_83_if #(.WIDTH(W)) bus ();

  ixc_skid_83 #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus.slave),
    .count    (count),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_xfer;
  int               n_cmp;
  int               n_bad;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle; returns whether the word was accepted into the buffer
  task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy,
                       input bit fl, input bit r, output bit acc);
    @(posedge clk);
    #1;
    rst           = r;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    acc = !r && iv && (bus.in_ready === 1'b1);
    if (acc && !fl) exp_q.push_back(d);
  endtask

  // Monitor: compares flags against model occupancy and pops on each output fire
  always @(negedge clk) begin
    bit infire, ofire;
    int exp_cnt;
    if (rst === 1'b1) begin
      exp_q.delete();
      exp_xfer = '0;
    end else if (rst === 1'b0) begin
      infire  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      ofire   = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
      exp_cnt = exp_q.size() - ((infire && !flush) ? 1 : 0);
      chk("count", W'(count), W'(exp_cnt));
      chk("out_valid", W'(bus.out_valid), W'(exp_cnt != 0));
      chk("in_ready", W'(bus.in_ready), W'(exp_cnt < 2));
      chk("xfer_cnt", W'(xfer_cnt), W'(exp_xfer));
      if (exp_cnt > 0) chk("out_data_head", bus.out_data, exp_q[0]);
      if (ofire) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_fire: got unexpected word %h expected none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q.pop_front());
        end
        exp_xfer = exp_xfer + 1'b1;
      end
      if (flush === 1'b1) exp_q.delete();
    end
  end

  task automatic drain(input string name);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b1, W'(1), 1'b1, 1'b0, 1'b1, acc);
    cycle(1'b1, W'(1), 1'b1, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit               acc;
    logic [W-1:0]     a, b, c, rnd;
    logic [CNT_W-1:0] xf_before;
    n_cmp = 0;
    n_bad = 0;
    exp_xfer = '0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // Reset with in_valid asserted: nothing captured
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_count", W'(count), W'(0));
    chk("rst_xfer", W'(xfer_cnt), W'(0));
    chk("rst_out_data", bus.out_data, W'(0));

    // Streaming 1..64 with out_ready held high
    for (int i = 1; i <= 64; i++) cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("stream_xfer", W'(xfer_cnt), W'(64));
    chk("stream_count", W'(count), W'(0));

    // Backpressure: A, B fill the buffer, C is refused until space opens
    do_reset();
    a = '1;
    b = W'(1);
    c = W'(83'h1234_5678_9abc_def0);
    cycle(1'b1, a, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, b, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, c, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("bp_count", W'(count), W'(2));
    chk("bp_in_ready", W'(bus.in_ready), W'(0));
    chk("bp_head", bus.out_data, a);
    chk("bp_c_refused", W'(acc), W'(0));
    cycle(1'b1, c, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("bp_head_stable", bus.out_data, a);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(1'b1, c, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_c_taken", W'(acc), W'(1));
    drain("bp");

    // Flush while full and head consumed
    cycle(1'b1, W'(83'hD), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, W'(83'hE), 1'b0, 1'b0, 1'b0, acc);
    xf_before = exp_xfer;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("fl_count", W'(count), W'(0));
    chk("fl_out_valid", W'(bus.out_valid), W'(0));
    chk("fl_in_ready", W'(bus.in_ready), W'(1));
    chk("fl_xfer", W'(xfer_cnt), W'(xf_before + 1'b1));

    // Mid-operation reset with both entries held
    cycle(1'b1, W'(83'h21), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, W'(83'h22), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, W'(83'h23), 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("mr_count", W'(count), W'(0));
    chk("mr_out_data", bus.out_data, W'(0));
    chk("mr_xfer", W'(xfer_cnt), W'(0));
    cycle(1'b1, W'(83'h5A5A), 1'b1, 1'b0, 1'b0, acc);
    drain("mr");

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 2000; i++) begin
      rnd = W'({$urandom(), $urandom(), $urandom()});
      cycle(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 250) == 0), acc);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    drain("rand");

    // Counter wrap: 65535 fires to reach FFFF, then one more
    do_reset();
    for (int i = 0; i < 65535; i++) cycle(1'b1, W'(i), 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("wrap_ffff", W'(xfer_cnt), W'(16'hFFFF));
    cycle(1'b1, W'(83'h77), 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("wrap_zero", W'(xfer_cnt), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
